// File: rtl/gcd_operand_loader_if.sv
// Board-side and core-side signals of the GCD operand loader, bundled for one port.
// master = loader (drives operands, start, result), slave = board/core environment.
interface gcd_operand_loader_if #(
    parameter int WIDTH = 8
);
    // Core handshake: core_start is a one-cycle request; core_done is a one-cycle
    // completion carrying core_result, honoured only while busy is high.
    logic [WIDTH-1:0] sw;
    logic             key_load_n;
    logic             core_done;
    logic [WIDTH-1:0] core_result;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             core_start;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic [1:0]       stage;

    modport master (
        input  sw, key_load_n, core_done, core_result,
        output op_a, op_b, core_start, busy, result, result_valid, stage
    );

    modport slave (
        output sw, key_load_n, core_done, core_result,
        input  op_a, op_b, core_start, busy, result, result_valid, stage
    );
endinterface

// File: rtl/gcd_operand_loader.sv
// Debounces the load key, captures operands A then B, starts the GCD core and
// holds its result until the next press begins a new computation.
module gcd_operand_loader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                  CLOCK_125_p,
    input  logic                  rst_n,
    gcd_operand_loader_if.master  bus,
    output logic [2:0]            dbg_state_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE_A = 3'd0,
        WAIT_B = 3'd1,
        START  = 3'd2,
        BUSY   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             level_q;
    logic [CW-1:0]    cnt_q;
    logic             press_q;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic [1:0]       stage_q, stage_d;

    // The counter only runs while the synchronized key disagrees with the
    // debounced level, so any agreeing sample restarts the stability window.
    always_ff @(posedge CLOCK_125_p or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= bus.key_load_n;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_125_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            stage_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            stage_q  <= stage_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE_A: begin
                if (press_q) begin
                    op_a_d  = bus.sw;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press_q) begin
                    op_b_d  = bus.sw;
                    state_d = START;
                end
            end
            START: state_d = BUSY;
            BUSY: begin
                if (bus.core_done) begin
                    result_d = bus.core_result;
                    valid_d  = 1'b1;
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                if (press_q) begin
                    op_a_d  = bus.sw;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            default: state_d = IDLE_A;
        endcase

        // Status outputs are decoded from the next state so they register in
        // step with the state they describe.
        start_d = (state_d == START);
        busy_d  = (state_d == START) || (state_d == BUSY);
        case (state_d)
            IDLE_A:  stage_d = 2'd0;
            WAIT_B:  stage_d = 2'd1;
            SHOW:    stage_d = 2'd3;
            default: stage_d = 2'd2;
        endcase
    end

    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.core_start   = start_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.stage        = stage_q;
    assign dbg_state_o      = state_q;
endmodule
